// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine.
package dma_pkg;

   // Transfer sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_FINISH
   } dma_state_e;

   // Byte offsets of the configuration registers
   localparam logic [4:0] DMA_SRC_OFF    = 5'h00;
   localparam logic [4:0] DMA_DST_OFF    = 5'h04;
   localparam logic [4:0] DMA_LEN_OFF    = 5'h08;
   localparam logic [4:0] DMA_CTRL_OFF   = 5'h0C;
   localparam logic [4:0] DMA_STATUS_OFF = 5'h10;

   // CTRL / STATUS bit positions
   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQEN_BIT  = 1;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;
   localparam int STATUS_ERR_BIT  = 2;

   // Replace only the bytes selected by be, keep the rest of old_v
   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_regs.sv
// Configuration register file for the DMA engine: device-port decode,
// register storage, W1C status and single-cycle response generation.
module dma_regs
   import dma_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int LenWidth     = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_cfg_req,
   input  logic                    i_cfg_we,
   input  logic [3:0]              i_cfg_be,
   input  logic [AddressWidth-1:0] i_cfg_addr,
   input  logic [DataWidth-1:0]    i_cfg_wdata,
   output logic                    o_cfg_rvalid,
   output logic [DataWidth-1:0]    o_cfg_rdata,
   output logic                    o_cfg_err,
   input  logic                    i_busy,
   input  logic                    i_done_set,
   input  logic                    i_err_set,
   output logic                    o_start,
   output logic [AddressWidth-1:0] o_src,
   output logic [AddressWidth-1:0] o_dst,
   output logic [LenWidth-1:0]     o_len,
   output logic                    o_irq
);

   logic [AddressWidth-1:0] r_src, r_dst;
   logic [LenWidth-1:0]     r_len;
   logic                    r_irq_en, r_done, r_err;
   logic                    r_cfg_rvalid, r_cfg_err;
   logic [DataWidth-1:0]    r_cfg_rdata;

   logic [4:0]           w_off;
   logic                 w_wr, w_bad, w_w1c_done, w_w1c_err;
   logic [DataWidth-1:0] w_rdata;
   logic                 w_unused;

   assign w_off    = {i_cfg_addr[4:2], 2'b00};
   assign w_bad    = (i_cfg_addr[4:2] > 3'd4);
   assign w_wr     = i_cfg_req & i_cfg_we;
   assign w_unused = ^{i_cfg_addr[AddressWidth-1:5], i_cfg_addr[1:0]};

   // Start is a one-cycle strobe and is dropped while a transfer is running
   assign o_start    = w_wr & (w_off == DMA_CTRL_OFF) & i_cfg_be[0] &
                       i_cfg_wdata[CTRL_START_BIT] & ~i_busy;
   assign w_w1c_done = w_wr & (w_off == DMA_STATUS_OFF) & i_cfg_be[0] &
                       i_cfg_wdata[STATUS_DONE_BIT];
   assign w_w1c_err  = w_wr & (w_off == DMA_STATUS_OFF) & i_cfg_be[0] &
                       i_cfg_wdata[STATUS_ERR_BIT];

   // Read-back mux; unmapped offsets and write-only START read as zero
   always_comb begin
      w_rdata = '0;
      case (w_off)
         DMA_SRC_OFF:    w_rdata = r_src;
         DMA_DST_OFF:    w_rdata = r_dst;
         DMA_LEN_OFF:    w_rdata = {{(DataWidth-LenWidth){1'b0}}, r_len};
         DMA_CTRL_OFF:   w_rdata[CTRL_IRQEN_BIT] = r_irq_en;
         DMA_STATUS_OFF: begin
            w_rdata[STATUS_BUSY_BIT] = i_busy;
            w_rdata[STATUS_DONE_BIT] = r_done;
            w_rdata[STATUS_ERR_BIT]  = r_err;
         end
         default:        w_rdata = '0;
      endcase
   end

   // Register storage, status flags and the registered device response
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
         r_irq_en     <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_cfg_rvalid <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_cfg_rdata  <= '0;
      end else begin
         r_cfg_rvalid <= i_cfg_req;
         r_cfg_err    <= i_cfg_req & w_bad;
         r_cfg_rdata  <= (i_cfg_req & ~i_cfg_we & ~w_bad) ? w_rdata : '0;
         // Transfer parameters are frozen while busy; low address bits forced to 0
         if (w_wr && !i_busy) begin
            case (w_off)
               DMA_SRC_OFF: r_src <= be_merge(r_src, i_cfg_wdata, i_cfg_be) & ~32'h3;
               DMA_DST_OFF: r_dst <= be_merge(r_dst, i_cfg_wdata, i_cfg_be) & ~32'h3;
               DMA_LEN_OFF: r_len <= LenWidth'(be_merge({{(32-LenWidth){1'b0}}, r_len},
                                                         i_cfg_wdata, i_cfg_be));
               default: ;
            endcase
         end
         if (w_wr && (w_off == DMA_CTRL_OFF) && i_cfg_be[0])
            r_irq_en <= i_cfg_wdata[CTRL_IRQEN_BIT];
         // Start and W1C clear, a set strobe from the sequencer always wins
         r_done <= (r_done & ~w_w1c_done & ~o_start) | i_done_set;
         r_err  <= (r_err  & ~w_w1c_err  & ~o_start) | i_err_set;
      end
   end

   assign o_src        = r_src;
   assign o_dst        = r_dst;
   assign o_len        = r_len;
   assign o_irq        = r_irq_en & (r_done | r_err);
   assign o_cfg_rvalid = r_cfg_rvalid;
   assign o_cfg_rdata  = r_cfg_rdata;
   assign o_cfg_err    = r_cfg_err;

endmodule

// File: rtl/dma_host.sv
// Single-channel word-copy DMA: config registers on the device port and a
// read-then-write sequencer driving the host port, one transaction in flight.
module dma_host
   import dma_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int LenWidth     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cfg_req_i,
   input  logic                    cfg_we_i,
   input  logic [3:0]              cfg_be_i,
   input  logic [AddressWidth-1:0] cfg_addr_i,
   input  logic [DataWidth-1:0]    cfg_wdata_i,
   output logic                    cfg_rvalid_o,
   output logic [DataWidth-1:0]    cfg_rdata_o,
   output logic                    cfg_err_o,
   output logic                    host_req_o,
   input  logic                    host_gnt_i,
   output logic [AddressWidth-1:0] host_addr_o,
   output logic                    host_we_o,
   output logic [3:0]              host_be_o,
   output logic [DataWidth-1:0]    host_wdata_o,
   input  logic                    host_rvalid_i,
   input  logic [DataWidth-1:0]    host_rdata_i,
   input  logic                    host_err_i,
   output logic                    irq_o
);

   dma_state_e r_state, w_state_nxt;

   logic [AddressWidth-1:0] r_cur_src, r_cur_dst;
   logic [LenWidth-1:0]     r_remaining;
   logic [DataWidth-1:0]    r_data;
   logic                    r_fail;

   logic                    w_start, w_busy, w_done_set, w_err_set;
   logic [AddressWidth-1:0] w_src, w_dst;
   logic [LenWidth-1:0]     w_len;

   assign w_busy    = (r_state != ST_IDLE);
   assign host_be_o = 4'hF;

   dma_regs #(
      .DataWidth    (DataWidth),
      .AddressWidth (AddressWidth),
      .LenWidth     (LenWidth)
   ) u_regs (
      .i_clk        (clk_i),
      .i_rst_n      (rst_ni),
      .i_cfg_req    (cfg_req_i),
      .i_cfg_we     (cfg_we_i),
      .i_cfg_be     (cfg_be_i),
      .i_cfg_addr   (cfg_addr_i),
      .i_cfg_wdata  (cfg_wdata_i),
      .o_cfg_rvalid (cfg_rvalid_o),
      .o_cfg_rdata  (cfg_rdata_o),
      .o_cfg_err    (cfg_err_o),
      .i_busy       (w_busy),
      .i_done_set   (w_done_set),
      .i_err_set    (w_err_set),
      .o_start      (w_start),
      .o_src        (w_src),
      .o_dst        (w_dst),
      .o_len        (w_len),
      .o_irq        (irq_o)
   );

   // Sequencer state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state and host-port outputs; outputs are pure state decodes so reset drops them at once
   always_comb begin
      w_state_nxt  = r_state;
      host_req_o   = 1'b0;
      host_we_o    = 1'b0;
      host_addr_o  = '0;
      host_wdata_o = '0;
      w_done_set   = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               if (w_len != '0) w_state_nxt = ST_RD_REQ;
               else             w_done_set  = 1'b1;
            end
         end
         ST_RD_REQ: begin
            host_req_o  = 1'b1;
            host_addr_o = r_cur_src;
            if (host_gnt_i) w_state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (host_rvalid_i) w_state_nxt = host_err_i ? ST_FINISH : ST_WR_REQ;
         end
         ST_WR_REQ: begin
            host_req_o   = 1'b1;
            host_we_o    = 1'b1;
            host_addr_o  = r_cur_dst;
            host_wdata_o = r_data;
            if (host_gnt_i) w_state_nxt = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (host_rvalid_i) begin
               if (host_err_i || (r_remaining == LenWidth'(1))) w_state_nxt = ST_FINISH;
               else                                             w_state_nxt = ST_RD_REQ;
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
            w_done_set  = ~r_fail;
            w_err_set   = r_fail;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Working copies of the transfer, advanced per completed write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cur_src   <= '0;
         r_cur_dst   <= '0;
         r_remaining <= '0;
         r_data      <= '0;
         r_fail      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start && (w_len != '0)) begin
                  r_cur_src   <= w_src;
                  r_cur_dst   <= w_dst;
                  r_remaining <= w_len;
                  r_fail      <= 1'b0;
               end
            end
            ST_RD_WAIT: begin
               if (host_rvalid_i) begin
                  r_data <= host_rdata_i;
                  if (host_err_i) r_fail <= 1'b1;
               end
            end
            ST_WR_WAIT: begin
               if (host_rvalid_i) begin
                  if (host_err_i) begin
                     r_fail <= 1'b1;
                  end else begin
                     r_cur_src   <= r_cur_src + AddressWidth'(4);
                     r_cur_dst   <= r_cur_dst + AddressWidth'(4);
                     r_remaining <= r_remaining - LenWidth'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_host.sv
// Scoreboard bench for dma_host: a bus model serves the host port, expected
// host transactions and config responses are queued and checked by monitors.
module tb_dma_host;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
   logic [3:0]  cfg_be_i = 4'h0;
   logic [31:0] cfg_addr_i = '0, cfg_wdata_i = '0;
   logic        cfg_rvalid_o, cfg_err_o;
   logic [31:0] cfg_rdata_o;
   logic        host_req_o, host_gnt_i, host_we_o;
   logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
   logic [3:0]  host_be_o;
   logic        host_rvalid_i, host_err_i, irq_o;

   always #5 clk_i = ~clk_i;

   dma_host dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_be_i(cfg_be_i),
      .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
      .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
      .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
      .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
      .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
      .irq_o(irq_o)
   );

   typedef struct { logic [31:0] rdata; logic err; logic chk; } cfg_exp_t;
   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } host_exp_t;

   cfg_exp_t    cfg_q[$];
   host_exp_t   host_q[$];
   logic [31:0] mem [logic [31:0]];
   int          n_vec = 0, n_err = 0;

   int          stall = 0;
   logic        stall_active = 1'b0;
   logic [31:0] stall_addr = '0;
   logic        granted = 1'b0;
   logic [31:0] g_addr, g_wdata;
   logic        g_we;

   localparam logic [31:0] SRC = 32'h00, DST = 32'h04, LEN = 32'h08, CTRL = 32'h0C, STAT = 32'h10;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEADBEEF;
   endfunction

   // Bus model: grant at the negedge, respond at the negedge after acceptance
   initial begin
      host_exp_t e;
      host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0; host_gnt_i = 1'b0;
         if (granted) begin
            granted = 1'b0;
            if (host_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL host_txn: unexpected addr %h we %b", g_addr, g_we);
            end else begin
               e = host_q.pop_front();
               check("host_addr", g_addr, e.addr);
               check("host_we", 32'(g_we), 32'(e.we));
               if (e.we) check("host_wdata", g_wdata, e.wdata);
            end
            host_rvalid_i = 1'b1;
            if (g_addr[31:20] == 12'h005) host_err_i = 1'b1;
            else if (g_we)                mem[g_addr] = g_wdata;
            else                          host_rdata_i = mem.exists(g_addr) ? mem[g_addr] : 32'h0;
         end else if (stall > 0 && (host_req_o || stall_active)) begin
            stall_active = 1'b1;
            check("stall_req", 32'(host_req_o), 32'h1);
            check("stall_addr", host_addr_o, stall_addr);
            stall--;
            if (stall == 0) stall_active = 1'b0;
         end else if (host_req_o) begin
            host_gnt_i = 1'b1; granted = 1'b1;
            g_addr = host_addr_o; g_we = host_we_o; g_wdata = host_wdata_o;
         end
      end
   end

   // Config response monitor
   initial begin
      cfg_exp_t c;
      forever begin
         @(negedge clk_i);
         if (cfg_rvalid_o) begin
            if (cfg_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL cfg_rsp: unexpected rvalid rdata %h", cfg_rdata_o);
            end else begin
               c = cfg_q.pop_front();
               check("cfg_err", 32'(cfg_err_o), 32'(c.err));
               if (c.chk) check("cfg_rdata", cfg_rdata_o, c.rdata);
            end
         end
      end
   end

   task automatic cfg_acc(input logic we, input logic [31:0] off, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd);
      cfg_exp_t e;
      @(negedge clk_i);
      cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = off; cfg_wdata_i = wd; cfg_be_i = be;
      e.err   = (off[4:2] > 3'd4);
      e.chk   = !we;
      e.rdata = e.err ? 32'h0 : exp_rd;
      cfg_q.push_back(e);
      @(negedge clk_i);
      cfg_req_i = 1'b0; cfg_we_i = 1'b0;
      check("cfg_rvalid_lat", 32'(cfg_rvalid_o), 32'h1);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      cfg_acc(1'b1, off, d, 4'hF, 32'h0);
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] exp_rd);
      cfg_acc(1'b0, off, 32'h0, 4'hF, exp_rd);
   endtask

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         host_q.push_back('{addr: s + 32'(4*i), we: 1'b0, wdata: 32'h0});
         host_q.push_back('{addr: d + 32'(4*i), we: 1'b1, wdata: mem_rd(s + 32'(4*i))});
      end
   endtask

   task automatic wait_irq(input string name);
      for (int i = 0; i < 400 && !irq_o; i++) @(negedge clk_i);
      check(name, 32'(irq_o), 32'h1);
   endtask

   task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
      wr(STAT, 32'h6);
      wr(SRC, s); wr(DST, d); wr(LEN, n); wr(CTRL, 32'h2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) mem[32'h0010_0000 + 32'(4*i)] = 32'(8'h11 * (i + 1));

      // Reset values
      #1;
      check("rst_req", 32'(host_req_o), 32'h0);
      check("rst_be", 32'(host_be_o), 32'hF);
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_addr", host_addr_o, 32'h0);
      check("rst_cfg_rvalid", 32'(cfg_rvalid_o), 32'h0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      rd(SRC, 0); rd(DST, 0); rd(LEN, 0); rd(CTRL, 0); rd(STAT, 0);

      // Byte enables, forced alignment, LEN truncation
      cfg_acc(1'b1, SRC, 32'hAABB_CCDF, 4'b0011, 32'h0);
      rd(SRC, 32'h0000_CCDC);
      wr(LEN, 32'h1234_5678);
      rd(LEN, 32'h0000_5678);

      // Basic 4-word copy
      setup(32'h0010_0000, 32'h0010_0100, 4);
      push_copy(32'h0010_0000, 32'h0010_0100, 4);
      wr(CTRL, 32'h3);
      wait_irq("copy_irq");
      rd(STAT, 32'h2);
      for (int i = 0; i < 4; i++)
         check("copy_mem", mem_rd(32'h0010_0100 + 32'(4*i)), 32'(8'h11 * (i + 1)));
      wr(STAT, 32'h2);
      check("copy_irq_clr", 32'(irq_o), 32'h0);
      rd(SRC, 32'h0010_0000);
      rd(LEN, 32'h4);

      // Zero-length start: DONE next cycle, no bus traffic
      wr(LEN, 32'h0);
      wr(CTRL, 32'h3);
      check("len0_irq", 32'(irq_o), 32'h1);
      rd(STAT, 32'h2);

      // Grant stall on the first read
      setup(32'h0010_0000, 32'h0010_0200, 2);
      push_copy(32'h0010_0000, 32'h0010_0200, 2);
      stall_addr = 32'h0010_0000;
      stall = 5;
      wr(CTRL, 32'h3);
      wait_irq("stall_irq");
      check("stall_left", 32'(stall), 32'h0);
      check("stall_mem0", mem_rd(32'h0010_0200), 32'h11);
      check("stall_mem1", mem_rd(32'h0010_0204), 32'h22);

      // Bus error on the first read
      setup(32'h0050_0000, 32'h0010_0300, 2);
      host_q.push_back('{addr: 32'h0050_0000, we: 1'b0, wdata: 32'h0});
      wr(CTRL, 32'h3);
      wait_irq("err_irq");
      rd(STAT, 32'h4);
      check("err_nowrite", 32'(mem.exists(32'h0010_0300)), 32'h0);

      // Busy protection and unmapped offset
      setup(32'h0010_0000, 32'h0010_0400, 8);
      push_copy(32'h0010_0000, 32'h0010_0400, 8);
      wr(CTRL, 32'h3);
      wr(DST, 32'h0);
      wr(CTRL, 32'h3);
      rd(32'h18, 32'h0);
      rd(DST, 32'h0010_0400);
      rd(STAT, 32'h1);
      wait_irq("busy_irq");
      rd(STAT, 32'h2);
      for (int i = 0; i < 8; i++)
         check("busy_mem", mem_rd(32'h0010_0400 + 32'(4*i)), 32'(8'h11 * (i + 1)));
      check("busy_dst0", 32'(mem.exists(32'h0)), 32'h0);

      // Destination wraps past the top of the address space
      setup(32'h0010_0000, 32'hFFFF_FFFC, 2);
      push_copy(32'h0010_0000, 32'hFFFF_FFFC, 2);
      wr(CTRL, 32'h3);
      wait_irq("wrap_irq");
      check("wrap_mem_hi", mem_rd(32'hFFFF_FFFC), 32'h11);
      check("wrap_mem_lo", mem_rd(32'h0), 32'h22);

      // Asynchronous reset while waiting for read data
      setup(32'h0010_0000, 32'h0010_0500, 4);
      host_q.push_back('{addr: 32'h0010_0000, we: 1'b0, wdata: 32'h0});
      wr(CTRL, 32'h3);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check("arst_req", 32'(host_req_o), 32'h0);
      check("arst_we", 32'(host_we_o), 32'h0);
      check("arst_addr", host_addr_o, 32'h0);
      check("arst_wdata", host_wdata_o, 32'h0);
      check("arst_irq", 32'(irq_o), 32'h0);
      check("arst_cfg", {cfg_rdata_o[29:0], cfg_rvalid_o, cfg_err_o}, 32'h0);
      check("arst_be", 32'(host_be_o), 32'hF);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      rd(STAT, 32'h0);
      rd(SRC, 32'h0);
      repeat (10) @(negedge clk_i);

      check("host_q_empty", 32'(host_q.size()), 32'h0);
      check("cfg_q_empty", 32'(cfg_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
